// File: rtl/display_monitor.sv
// Passive monitor for a 4-digit multiplexed 7-segment clock display.
// Recovers HH:MM and the seconds dot from the anode/segment lines driving the display.
module display_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 250000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] led7_an_i,
    input  logic [7:0] led7_seg_i,
    output logic [5:0] hour_o,
    output logic [5:0] minute_o,
    output logic       dot_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       stale_o
);

    localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] STALE_MAX = TW'(TIMEOUT);

    localparam logic [3:0] AN3   = 4'b0111;
    localparam logic [3:0] AN2   = 4'b1011;
    localparam logic [3:0] AN1   = 4'b1101;
    localparam logic [3:0] AN0   = 4'b1110;
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {WAIT3, GOT3, GOT2, GOT1} state_e;

    state_e        state_q, state_d;
    logic [3:0]    an_q;
    logic [7:0]    seg_q;
    logic [SW-1:0] stab_q, stab_d;
    logic          held_q, held_d;
    logic [3:0]    dig3_q, dig3_d, dig2_q, dig2_d, dig1_q, dig1_d;
    logic          bad_q, bad_d;
    logic          dotc_q, dotc_d;
    logic [5:0]    hour_q, hour_d, minute_q, minute_d;
    logic          dot_q, dot_d, valid_q, valid_d, err_q, err_d;
    logic [TW-1:0] stale_q, stale_d;

    logic          changed, accept, an_onehot;
    logic [4:0]    dig_dec;
    logic          dig_bad;
    logic [3:0]    dig_val;
    logic [3:0]    exp_an;
    logic [6:0]    hour_calc, minute_calc;
    logic          frame_ok;

    // Bit 4 of the result flags a segment pattern that is not a decimal digit.
    function automatic logic [4:0] decode_digit(input logic [7:0] seg);
        logic [4:0] r;
        case ({seg[7:1], 1'b1})
            8'h03:   r = 5'd0;
            8'h9F:   r = 5'd1;
            8'h25:   r = 5'd2;
            8'h0D:   r = 5'd3;
            8'h99:   r = 5'd4;
            8'h49:   r = 5'd5;
            8'h41:   r = 5'd6;
            8'h1F:   r = 5'd7;
            8'h01:   r = 5'd8;
            8'h09:   r = 5'd9;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    always_comb begin
        changed = (led7_an_i != an_q) || (led7_seg_i != seg_q);
        stab_d  = changed ? '0 : ((stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1);
        held_d  = (stab_q == STAB_MAX) && !changed;
        // held_q marks a dwell already accepted, so each dwell fires once.
        accept  = (stab_q == STAB_MAX) && !held_q && (an_q != BLANK);
        an_onehot = (an_q == AN3) || (an_q == AN2) || (an_q == AN1) || (an_q == AN0);
        dig_dec = decode_digit(seg_q);
        dig_bad = dig_dec[4];
        dig_val = dig_dec[3:0];
    end

    always_comb begin
        hour_calc   = {3'b000, dig3_q} * 7'd10 + {3'b000, dig2_q};
        minute_calc = {3'b000, dig1_q} * 7'd10 + {3'b000, dig_val};
        frame_ok    = !bad_q && !dig_bad && (hour_calc <= 7'd23) && (minute_calc <= 7'd59);
        unique case (state_q)
            WAIT3:   exp_an = AN3;
            GOT3:    exp_an = AN2;
            GOT2:    exp_an = AN1;
            default: exp_an = AN0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dig3_d   = dig3_q;
        dig2_d   = dig2_q;
        dig1_d   = dig1_q;
        bad_d    = bad_q;
        dotc_d   = dotc_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        dot_d    = dot_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (accept) begin
            if (an_q == exp_an) begin
                unique case (state_q)
                    WAIT3: begin
                        dig3_d  = dig_val;
                        bad_d   = dig_bad;
                        state_d = GOT3;
                    end
                    GOT3: begin
                        dig2_d  = dig_val;
                        bad_d   = bad_q | dig_bad;
                        dotc_d  = ~seg_q[0];
                        state_d = GOT2;
                    end
                    GOT2: begin
                        dig1_d  = dig_val;
                        bad_d   = bad_q | dig_bad;
                        state_d = GOT1;
                    end
                    GOT1: begin
                        state_d = WAIT3;
                        if (frame_ok) begin
                            hour_d   = hour_calc[5:0];
                            minute_d = minute_calc[5:0];
                            dot_d    = dotc_q;
                            valid_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end else if (state_q == WAIT3) begin
                // Lone AN2..AN0 is resync noise; only a multi-hot anode is an error.
                err_d = !an_onehot;
            end else begin
                err_d = 1'b1;
                if (an_q == AN3) begin
                    dig3_d  = dig_val;
                    bad_d   = dig_bad;
                    state_d = GOT3;
                end else begin
                    state_d = WAIT3;
                end
            end
        end
        stale_d = valid_d ? '0 : ((stale_q == STALE_MAX) ? stale_q : stale_q + 1'b1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_q     <= BLANK;
            seg_q    <= 8'hFF;
            stab_q   <= '0;
            held_q   <= 1'b0;
            state_q  <= WAIT3;
            dig3_q   <= '0;
            dig2_q   <= '0;
            dig1_q   <= '0;
            bad_q    <= 1'b0;
            dotc_q   <= 1'b0;
            hour_q   <= '0;
            minute_q <= '0;
            dot_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= '0;
        end else begin
            an_q     <= led7_an_i;
            seg_q    <= led7_seg_i;
            stab_q   <= stab_d;
            held_q   <= held_d;
            state_q  <= state_d;
            dig3_q   <= dig3_d;
            dig2_q   <= dig2_d;
            dig1_q   <= dig1_d;
            bad_q    <= bad_d;
            dotc_q   <= dotc_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            dot_q    <= dot_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
        end
    end

    assign hour_o   = hour_q;
    assign minute_o = minute_q;
    assign dot_o    = dot_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign stale_o  = (stale_q == STALE_MAX);

endmodule

// File: tb/tb_display_monitor.sv
// Bench for display_monitor: directed frame table, hand-written corner sequences
// and random anode/segment traffic, all checked every cycle against a behavioural model.
module tb_display_monitor;

    localparam int S = 4;
    localparam int T = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an = 4'hF;
    logic [7:0] seg = 8'hFF;
    logic [5:0] hour, minute;
    logic       dot, valid, err, stale;

    display_monitor #(.STABLE_CYCLES(S), .TIMEOUT(T)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .led7_an_i (an),
        .led7_seg_i(seg),
        .hour_o    (hour),
        .minute_o  (minute),
        .dot_o     (dot),
        .valid_o   (valid),
        .err_o     (err),
        .stale_o   (stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, vcnt = 0, ecnt = 0, last_valid_cyc = -1;
    logic stale_at_valid = 1'b1;

    // Model state: registered input copy, how many edges it has been held,
    // digits collected so far in the current frame, and last valid outputs.
    logic [3:0] r_an;
    logic [7:0] r_seg;
    int         run;
    int         n;
    int         digs[4];
    logic       m_dotc;
    int         m_hour, m_min;
    logic       m_dot, m_valid, m_err;
    int         since;

    logic [7:0] codes[10];

    function automatic int dec(input logic [7:0] s);
        logic [7:0] p;
        p = {s[7:1], 1'b1};
        for (int i = 0; i < 10; i++)
            if (codes[i] == p) return i;
        return -1;
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            4'hF:    return -2;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        r_an = 4'hF; r_seg = 8'hFF; run = 1; n = 0;
        m_hour = 0; m_min = 0; m_dot = 1'b0; m_dotc = 1'b0;
        m_valid = 1'b0; m_err = 1'b0; since = 0;
    endtask

    task automatic take(input int idx, input logic [7:0] s);
        int d, h, mi;
        d = dec(s);
        if (idx == -2) return;
        if (n == 0) begin
            if (idx == 3) begin digs[0] = d; n = 1; end
            else if (idx == -1) m_err = 1'b1;
        end else if (idx == 3 - n) begin
            digs[n] = d;
            if (idx == 2) m_dotc = ~s[0];
            n++;
            if (n == 4) begin
                n = 0;
                h  = digs[0] * 10 + digs[1];
                mi = digs[2] * 10 + digs[3];
                if (digs[0] >= 0 && digs[1] >= 0 && digs[2] >= 0 && digs[3] >= 0 &&
                    h <= 23 && mi <= 59) begin
                    m_valid = 1'b1; m_hour = h; m_min = mi; m_dot = m_dotc;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            m_err = 1'b1;
            if (idx == 3) begin digs[0] = d; n = 1; end
            else n = 0;
        end
    endtask

    task automatic model_step();
        m_valid = 1'b0; m_err = 1'b0;
        if (!rst_n) begin model_reset(); return; end
        if (run == S) take(an_idx(r_an), r_seg);
        if (an !== r_an || seg !== r_seg) begin
            r_an = an; r_seg = seg; run = 1;
        end else if (run <= S) begin
            run++;
        end
        if (m_valid) since = 0;
        else since++;
    endtask

    task automatic tick();
        logic [15:0] expv, actv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        expv = {6'(m_hour), 6'(m_min), m_dot, m_valid, m_err, (since >= T)};
        actv = {hour, minute, dot, valid, err, stale};
        checks++;
        if (actv !== expv) begin
            errors++;
            $display("FAIL outputs cyc=%0d {h,m,dot,v,e,stale} got=%h want=%h", cyc, actv, expv);
        end
        if (valid) begin vcnt++; last_valid_cyc = cyc; stale_at_valid = stale; end
        if (err) ecnt++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int cycles);
        an = a; seg = s;
        repeat (cycles) tick();
    endtask

    task automatic frame(input logic [31:0] segs, input int hold);
        dwell(4'b0111, segs[31:24], hold);
        dwell(4'b1011, segs[23:16], hold);
        dwell(4'b1101, segs[15:8],  hold);
        dwell(4'b1110, segs[7:0],   hold);
    endtask

    typedef struct {
        logic [31:0] segs;
        int          hold;
        int          ev;
        int          ee;
        int          h;
        int          m;
        int          d;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int rise, k, r, dg;
        logic [3:0] a;
        logic [7:0] s;

        codes = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        tbl[0] = '{32'h9F240D99, 100, 1, 0, 12, 34, 1};
        tbl[1] = '{32'h25490303, 100, 0, 1, 12, 34, 1};
        tbl[2] = '{32'h03030303, 10, 1, 0,  0,  0, 0};
        tbl[3] = '{32'h25990303, 10, 0, 1,  0,  0, 0};
        tbl[4] = '{32'h9F404909, 10, 1, 0, 16, 59, 1};
        tbl[5] = '{32'h03034103, 10, 0, 1, 16, 59, 1};
        tbl[6] = '{32'h030303FF, 10, 0, 1, 16, 59, 1};
        tbl[7] = '{32'h250C4909, 10, 1, 0, 23, 59, 1};
        tbl[8] = '{32'h0301491F, 10, 1, 0,  8, 57, 0};

        model_reset();
        repeat (3) tick();
        check("reset_outputs", int'({hour, minute, dot, valid, err, stale}), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 9; i++) begin
            vcnt = 0; ecnt = 0;
            frame(tbl[i].segs, tbl[i].hold);
            check($sformatf("tbl%0d_valid", i), vcnt, tbl[i].ev);
            check($sformatf("tbl%0d_err", i), ecnt, tbl[i].ee);
            check($sformatf("tbl%0d_hour", i), int'(hour), tbl[i].h);
            check($sformatf("tbl%0d_minute", i), int'(minute), tbl[i].m);
            check($sformatf("tbl%0d_dot", i), int'(dot), tbl[i].d);
        end

        // Out-of-order anode, then a clean 23:59 frame.
        vcnt = 0; ecnt = 0;
        dwell(4'b0111, 8'h25, 10);
        dwell(4'b1101, 8'h0D, 10);
        check("order_err", ecnt, 1);
        check("order_noval", vcnt, 0);
        frame(32'h250D4909, 10);
        check("order_recover_valid", vcnt, 1);
        check("order_recover_hour", int'(hour), 23);
        check("order_recover_minute", int'(minute), 59);
        check("order_recover_dot", int'(dot), 0);

        // Blank gaps and a short segment glitch before the AN1 dwell settles.
        vcnt = 0; ecnt = 0;
        dwell(4'b0111, 8'h9F, 10);
        dwell(4'hF,    8'hFF, 10);
        dwell(4'b1011, 8'h08, 10);
        dwell(4'hF,    8'hFF, 3);
        dwell(4'b1101, 8'h99, 2);
        dwell(4'b1101, 8'h03, 2);
        dwell(4'b1101, 8'h99, 10);
        dwell(4'b1110, 8'h49, 10);
        check("glitch_valid", vcnt, 1);
        check("glitch_err", ecnt, 0);
        check("glitch_hour", int'(hour), 19);
        check("glitch_minute", int'(minute), 45);
        check("glitch_dot", int'(dot), 1);

        // Idle until stale, then a legal frame must clear it in its valid cycle.
        an = 4'hF; seg = 8'hFF;
        rise = -1;
        for (int i = 0; i < T + 50 && rise < 0; i++) begin
            tick();
            if (stale) rise = cyc;
        end
        check("stale_delay", (rise < 0) ? -1 : rise - last_valid_cyc, T);
        check("stale_high", int'(stale), 1);
        vcnt = 0;
        frame(32'h9F240D99, 10);
        check("stale_frame_valid", vcnt, 1);
        check("stale_clear_at_valid", int'(stale_at_valid), 0);

        // Reset after GOT2: no pulse, outputs cleared, partial AN1/AN0 does nothing.
        dwell(4'b0111, 8'h9F, 10);
        dwell(4'b1011, 8'h24, 10);
        vcnt = 0; ecnt = 0;
        an = 4'hF; seg = 8'hFF;
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", int'({hour, minute, dot, valid, err, stale}), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        dwell(4'b1101, 8'h0D, 10);
        dwell(4'b1110, 8'h99, 10);
        check("reset_partial_valid", vcnt, 0);
        check("reset_partial_err", ecnt, 0);
        check("reset_partial_hour", int'(hour), 0);

        // Random traffic: mostly in-order anodes, some blanks, strays and junk segments.
        k = 3;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                a = ~(4'b0001 << k);
                k = (k == 0) ? 3 : k - 1;
            end else if (r < 85) begin
                a = 4'hF;
            end else if (r < 92) begin
                a = ~(4'b0001 << $urandom_range(0, 3));
            end else begin
                a = 4'($urandom_range(0, 15));
            end
            if (a == 4'b0111) dg = $urandom_range(0, 2);
            else if (a == 4'b1101) dg = $urandom_range(0, 5);
            else dg = $urandom_range(0, 9);
            s = {codes[dg][7:1], 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 19) == 0) s = 8'($urandom);
            dwell(a, s, $urandom_range(1, 7));
        end
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
